x4xx_gpio_tx_arbiter: RTL
=========================

// Module: x4xx_gpio_tx_arbiter
//
// PURPOSE
//   Shares the single sample-driven GPIO line between NUM_CHANNELS TX channels.
//   - Channels request ownership; the block grants it round-robin.
//   - While a channel owns the line, one configurable bit of one sample of that
//     channel's TX word drives gpio_out on each strobe.
//   - Sits in the radio clock domain, between the radio TX datapath and the
//     GPIO output mux.
//
// PARAMETERS
//   NUM_CHANNELS  4   number of TX channels / requesters (1..8)
//   RADIO_SPC     1   samples per radio_clk per channel; each sample is 32 bit
//   HOLD_W        16  width of the hold and gap counters
//
// PORTS
//   radio_clk     in   1                       radio clock
//   radio_rst     in   1                       reset, synchronous, active-high
//   cfg_wr        in   1                       config write strobe
//   cfg_addr      in   2                       0=CTRL 1=HOLD 2=GAP
//   cfg_data      in   32                      config write data
//   chan_req      in   NUM_CHANNELS            per-channel ownership request (level)
//   tx_data       in   32*RADIO_SPC*NUM_CHANNELS  TX samples; ch c, sample s at [32*(c*RADIO_SPC+s)+:32]
//   tx_stb        in   NUM_CHANNELS            per-channel sample valid
//   chan_grant    out  NUM_CHANNELS            one-hot owner, all zero when none
//   gpio_out      out  1                       driven GPIO level
//   gpio_oe       out  1                       high while an owner exists
//
// BEHAVIOUR
//   Registers (all reset to 0):
//   - CTRL[0] enable
//   - CTRL[5:1] bit_sel
//   - CTRL[8:6] sample_sel, clipped to RADIO_SPC-1
//   - HOLD[HOLD_W-1:0] minimum owner cycles
//   - GAP[HOLD_W-1:0] idle cycles between owners
//   - A write takes effect the cycle after cfg_wr.
//   Reset: chan_grant=0, gpio_out=0, gpio_oe=0, FSM=IDLE, rr pointer=0, counters=0.
//   FSM:
//   - IDLE: if enable && |chan_req, grant the first requester at or after the
//     rr pointer (wrapping). chan_grant registers 1 cycle after the request is
//     seen. Load hold_cnt=HOLD and go to OWN.
//   - OWN: gpio_oe=1. On tx_stb[owner], next cycle
//     gpio_out = tx_data[32*(owner*RADIO_SPC+sample_sel)+bit_sel].
//     With no strobe, gpio_out holds its value. Other channels' strobes are ignored.
//     hold_cnt decrements to 0 and saturates there. Release when hold_cnt==0 &&
//     !chan_req[owner]. On release: rr pointer = owner+1 mod NUM_CHANNELS,
//     load gap_cnt=GAP, go to GAP (or IDLE if GAP==0).
//   - GAP: chan_grant=0, gpio_oe=0, gpio_out=0. gap_cnt decrements; at 0 go to IDLE.
//   Boundaries:
//   - Request dropped while hold_cnt>0: ownership is kept until hold expires.
//   - enable cleared in any state: next cycle FSM=IDLE; chan_grant, gpio_oe and
//     gpio_out =0; rr pointer unchanged; no GAP is inserted.
//   - Single requester re-requesting: it is granted again after the GAP.
//   - Strobe on the same cycle as release: it is ignored (output goes to 0).
//   - HOLD=0: release is allowed the first OWN cycle after chan_req drops.
//   - radio_rst mid-ownership: everything returns to reset values the next cycle.
//
// CONFIGURATION
//   X4XX_GPIO_ARB_STATS_EN defined:
//   - Adds output grant_count[15:0] (after gpio_oe): number of IDLE->OWN
//     transitions, wraps at 0xFFFF->0, reset 0.
//   - Adds output last_owner[2:0]: index of the most recent owner, reset 0.
//   X4XX_GPIO_ARB_STATS_EN undefined: these ports and their logic are absent;
//   all other behaviour is identical.
//
// TESTING
//   1. enable=1, HOLD=0, GAP=0, chan_req=0001; ch0 stb with sample bit0=1 ->
//      chan_grant=0001 one cycle after the request, gpio_out=1 one cycle after stb.
//   2. chan_req=1111, HOLD=4, each request dropped right after its grant ->
//      grants follow 0001,0010,0100,1000,0001; each lasts exactly 5 OWN cycles.
//   3. bit_sel=17, RADIO_SPC=2, sample_sel=1, owner ch2, tx_data bit 32*5+17=1 ->
//      gpio_out=1; strobes from other channels leave gpio_out unchanged.
//   4. GAP=3, owner releases -> 3 cycles with gpio_oe=0 and gpio_out=0, then
//      the next grant.
//   5. enable cleared while in OWN with HOLD=100 -> next cycle chan_grant=0,
//      gpio_oe=0, gpio_out=0; radio_rst mid-OWN gives the same result.
//   6. With X4XX_GPIO_ARB_STATS_EN, 65537 grants -> grant_count=1 and
//      last_owner matches the final owner.

Source files
------------

// File: rtl/x4xx_gpio_tx_arbiter.sv
// x4xx_gpio_tx_arbiter: round-robin ownership of the shared GPIO TX line; the owner's selected sample bit drives gpio_out on each strobe
// Ports: radio_clk/radio_rst (sync, active-high); cfg_wr/cfg_addr/cfg_data write CTRL(0), HOLD(1), GAP(2);
//   chan_req/tx_data/tx_stb from the TX channels; chan_grant (one-hot owner), gpio_out, gpio_oe to the GPIO mux.
// Build option X4XX_GPIO_ARB_STATS_EN adds grant_count (IDLE->OWN count) and last_owner outputs.
module x4xx_gpio_tx_arbiter #(
  parameter int NUM_CHANNELS = 4,
  parameter int RADIO_SPC    = 1,
  parameter int HOLD_W       = 16
) (
  input  logic                                 radio_clk,
  input  logic                                 radio_rst,
  input  logic                                 cfg_wr,
  input  logic [1:0]                           cfg_addr,
  input  logic [31:0]                          cfg_data,
  input  logic [NUM_CHANNELS-1:0]              chan_req,
  input  logic [32*RADIO_SPC*NUM_CHANNELS-1:0] tx_data,
  input  logic [NUM_CHANNELS-1:0]              tx_stb,
  output logic [NUM_CHANNELS-1:0]              chan_grant,
  output logic                                 gpio_out,
  output logic                                 gpio_oe
`ifdef X4XX_GPIO_ARB_STATS_EN
  ,
  output logic [15:0]                          grant_count,
  output logic [2:0]                           last_owner
`endif
);
  localparam int IW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
  localparam int DW = 32 * RADIO_SPC * NUM_CHANNELS;
  localparam int PW = $clog2(DW);
  localparam logic [2:0] SMAX = 3'(RADIO_SPC - 1);
  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;
  state_t                  state_q;
  logic                    en_q;
  logic [4:0]              bsel_q;
  logic [2:0]              ssel_q;
  logic [HOLD_W-1:0]       hold_cfg_q, gap_cfg_q, hold_q, gap_q;
  logic [IW-1:0]           rr_q, owner_q, pick_d;
  logic [NUM_CHANNELS-1:0] grant_q, rot_d;
  logic                    out_q, oe_q, bit_d;
  logic [2:0]              ssel_d;
  logic [PW-1:0]           pos_d;
  logic                    unused_cfg;
  assign unused_cfg = ^cfg_data;
  assign chan_grant = grant_q;
  assign gpio_out = out_q;
  assign gpio_oe = oe_q;
  // rotate requests so bit 0 is the rr pointer; the lowest set bit wins
  always_comb begin
    rot_d = NUM_CHANNELS'({chan_req, chan_req} >> rr_q);
    pick_d = rr_q;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--)
      if (rot_d[i]) pick_d = IW'((int'(rr_q) + i) % NUM_CHANNELS);
  end
  always_comb begin
    ssel_d = (ssel_q > SMAX) ? SMAX : ssel_q;
    pos_d = PW'(32 * (RADIO_SPC * int'(owner_q) + int'(ssel_d)) + int'(bsel_q));
    bit_d = tx_data[pos_d];
  end
  always_ff @(posedge radio_clk) begin
    if (radio_rst) begin
      state_q    <= IDLE;
      en_q       <= 1'b0;
      bsel_q     <= '0;
      ssel_q     <= '0;
      hold_cfg_q <= '0;
      gap_cfg_q  <= '0;
      hold_q     <= '0;
      gap_q      <= '0;
      rr_q       <= '0;
      owner_q    <= '0;
      grant_q    <= '0;
      out_q      <= 1'b0;
      oe_q       <= 1'b0;
`ifdef X4XX_GPIO_ARB_STATS_EN
      grant_count <= '0;
      last_owner  <= '0;
`endif
    end else begin
      if (cfg_wr && cfg_addr == 2'd0) begin
        en_q   <= cfg_data[0];
        bsel_q <= cfg_data[5:1];
        ssel_q <= cfg_data[8:6];
      end
      if (cfg_wr && cfg_addr == 2'd1) hold_cfg_q <= cfg_data[HOLD_W-1:0];
      if (cfg_wr && cfg_addr == 2'd2) gap_cfg_q <= cfg_data[HOLD_W-1:0];
      // disabling drops ownership immediately and skips the gap
      if (!en_q) begin
        state_q <= IDLE;
        grant_q <= '0;
        oe_q    <= 1'b0;
        out_q   <= 1'b0;
      end else if (state_q == IDLE) begin
        if (|chan_req) begin
          state_q <= OWN;
          owner_q <= pick_d;
          grant_q <= NUM_CHANNELS'(1) << pick_d;
          oe_q    <= 1'b1;
          hold_q  <= hold_cfg_q;
`ifdef X4XX_GPIO_ARB_STATS_EN
          grant_count <= grant_count + 16'd1;
          last_owner  <= 3'(pick_d);
`endif
        end
      end else if (state_q == OWN) begin
        // release wins over a same-cycle strobe
        if (hold_q == '0 && !chan_req[owner_q]) begin
          state_q <= (gap_cfg_q == '0) ? IDLE : GAP;
          gap_q   <= gap_cfg_q;
          rr_q    <= (owner_q == IW'(NUM_CHANNELS - 1)) ? '0 : owner_q + 1'b1;
          grant_q <= '0;
          oe_q    <= 1'b0;
          out_q   <= 1'b0;
        end else begin
          hold_q <= (hold_q == '0) ? '0 : hold_q - 1'b1;
          if (tx_stb[owner_q]) out_q <= bit_d;
        end
      end else begin
        gap_q   <= gap_q - 1'b1;
        state_q <= (gap_q > HOLD_W'(1)) ? GAP : IDLE;
      end
    end
  end
endmodule
